// File: rtl/gpr_wport_arbiter.sv
// Arbitrates WB commits and buffered long-latency results onto the single GPR write port.
// Optional feature macro: GPR_ARB_BYPASS_EN (LL result skips an empty FIFO when WB is idle).
package core_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int RF_ADDR_WIDTH = 5;
endpackage

module gpr_wport_arbiter #(
  parameter int DATA_WIDTH    = core_pkg::DATA_WIDTH,
  parameter int RF_ADDR_WIDTH = core_pkg::RF_ADDR_WIDTH,
  parameter int FIFO_DEPTH    = 2,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     wb_valid_i,
  input  logic [RF_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic [DATA_WIDTH-1:0]    wb_wdata_i,
  output logic                     wb_stall_o,
  input  logic                     lu_valid_i,
  output logic                     lu_ready_o,
  input  logic [RF_ADDR_WIDTH-1:0] lu_rd_i,
  input  logic [DATA_WIDTH-1:0]    lu_wdata_i,
  output logic                     gpr_we_o,
  output logic [RF_ADDR_WIDTH-1:0] gpr_waddr_o,
  output logic [DATA_WIDTH-1:0]    gpr_wdata_o,
  output logic                     lu_pending_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);
  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [RF_ADDR_WIDTH-1:0] RD_ZERO = {RF_ADDR_WIDTH{1'b0}};

  logic [RF_ADDR_WIDTH-1:0] rd_mem_r   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem_r [FIFO_DEPTH];
  logic [PTR_W:0]           wptr_r;
  logic [PTR_W:0]           rptr_r;
  logic [AGE_W-1:0]         age_r;

  logic                     empty_s;
  logic                     full_s;
  logic                     bypass_s;
  logic                     push_s;
  logic                     grant_ll_s;
  logic                     grant_wb_s;
  logic                     win_valid_s;
  logic [RF_ADDR_WIDTH-1:0] win_rd_s;
  logic [DATA_WIDTH-1:0]    win_data_s;

  // Extra MSB on the pointers separates "full" from "empty" when the index bits match.
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[PTR_W] != rptr_r[PTR_W]) &&
                   (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]);

`ifdef GPR_ARB_BYPASS_EN
  assign bypass_s = lu_valid_i && empty_s && !wb_valid_i;
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s       = lu_valid_i && !full_s && !bypass_s;
  assign lu_ready_o   = !full_s;
  assign lu_pending_o = !empty_s;
  assign wb_stall_o   = wb_valid_i && grant_ll_s;

  // Fixed-priority write-port arbitration: aged LL head, then WB, then any LL, then bypass.
  always_comb begin
    grant_ll_s  = 1'b0;
    grant_wb_s  = 1'b0;
    win_valid_s = 1'b0;
    win_rd_s    = RD_ZERO;
    win_data_s  = {DATA_WIDTH{1'b0}};
    if (!empty_s && (age_r >= AGE_MAX)) begin
      grant_ll_s = 1'b1;
    end else if (wb_valid_i) begin
      grant_wb_s = 1'b1;
    end else if (!empty_s) begin
      grant_ll_s = 1'b1;
    end else begin
      grant_ll_s = 1'b0;
    end
    if (grant_ll_s) begin
      win_valid_s = 1'b1;
      win_rd_s    = rd_mem_r[rptr_r[PTR_W-1:0]];
      win_data_s  = data_mem_r[rptr_r[PTR_W-1:0]];
    end else if (grant_wb_s) begin
      win_valid_s = 1'b1;
      win_rd_s    = wb_rd_i;
      win_data_s  = wb_wdata_i;
    end else if (bypass_s) begin
      win_valid_s = 1'b1;
      win_rd_s    = lu_rd_i;
      win_data_s  = lu_wdata_i;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // FIFO read/write pointers; a pop is exactly an LL grant.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_r <= {(PTR_W+1){1'b0}};
      rptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end else begin
        wptr_r <= wptr_r;
      end
      if (grant_ll_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // FIFO payload storage; contents are meaningless outside the pointer window.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      rd_mem_r[wptr_r[PTR_W-1:0]]   <= lu_rd_i;
      data_mem_r[wptr_r[PTR_W-1:0]] <= lu_wdata_i;
    end
  end

  // Saturating age of the FIFO head; restarts for every new head.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      age_r <= {AGE_W{1'b0}};
    end else if (empty_s || grant_ll_s) begin
      age_r <= {AGE_W{1'b0}};
    end else if (age_r != AGE_MAX) begin
      age_r <= age_r + AGE_ONE;
    end else begin
      age_r <= age_r;
    end
  end

  // Registered write port; rd=0 consumes the grant but suppresses the write and holds addr/data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gpr_we_o    <= 1'b0;
      gpr_waddr_o <= RD_ZERO;
      gpr_wdata_o <= {DATA_WIDTH{1'b0}};
    end else if (win_valid_s && (win_rd_s != RD_ZERO)) begin
      gpr_we_o    <= 1'b1;
      gpr_waddr_o <= win_rd_s;
      gpr_wdata_o <= win_data_s;
    end else begin
      gpr_we_o    <= 1'b0;
      gpr_waddr_o <= gpr_waddr_o;
      gpr_wdata_o <= gpr_wdata_o;
    end
  end

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Self-checking bench for gpr_wport_arbiter: directed scenarios plus random traffic
// against a queue-based reference model. Honours GPR_ARB_BYPASS_EN like the design.
module tb_gpr_wport_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int MW    = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          wb_valid_i = 1'b0;
  logic [AW-1:0] wb_rd_i = '0;
  logic [DW-1:0] wb_wdata_i = '0;
  logic          wb_stall_o;
  logic          lu_valid_i = 1'b0;
  logic          lu_ready_o;
  logic [AW-1:0] lu_rd_i = '0;
  logic [DW-1:0] lu_wdata_i = '0;
  logic          gpr_we_o;
  logic [AW-1:0] gpr_waddr_o;
  logic [DW-1:0] gpr_wdata_o;
  logic          lu_pending_o;

  gpr_wport_arbiter #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_wdata_i(wb_wdata_i), .wb_stall_o(wb_stall_o),
    .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o), .lu_rd_i(lu_rd_i), .lu_wdata_i(lu_wdata_i),
    .gpr_we_o(gpr_we_o), .gpr_waddr_o(gpr_waddr_o), .gpr_wdata_o(gpr_wdata_o),
    .lu_pending_o(lu_pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] d; } ent_t;

  // Reference model: LL results waiting in arrival order, plus the head's waiting time.
  ent_t          ll_q[$];
  int            age;
  logic          exp_we;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic          exp_stall, exp_ready, exp_pending;
  logic          obs_stall, obs_ready, obs_pending;
  int            total = 0;
  int            bad = 0;

  task automatic model_reset();
    ll_q.delete();
    age       = 0;
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  // One clock cycle: sample combinational outputs mid-cycle, predict, cross the edge.
  task automatic tick();
    int   sz;
    logic ll_w, wb_w, byp, has, acc;
    ent_t e, in_e;
    #2;
    sz  = ll_q.size();
    byp = 1'b0;
`ifdef GPR_ARB_BYPASS_EN
    byp = (sz == 0) && !wb_valid_i && lu_valid_i;
`endif
    ll_w        = (sz != 0) && ((age >= MW) || !wb_valid_i);
    wb_w        = wb_valid_i && !ll_w;
    exp_stall   = wb_valid_i && ll_w;
    exp_ready   = (sz < DEPTH);
    exp_pending = (sz != 0);
    obs_stall   = wb_stall_o;
    obs_ready   = lu_ready_o;
    obs_pending = lu_pending_o;
    acc  = lu_valid_i && (sz < DEPTH);
    in_e = {lu_rd_i, lu_wdata_i};
    has  = 1'b1;
    e    = '0;
    if (ll_w) e = ll_q[0];
    else if (wb_w) e = {wb_rd_i, wb_wdata_i};
    else if (byp) e = in_e;
    else has = 1'b0;
    @(posedge clk_i);
    if (ll_w) begin
      ll_q.delete(0);
      age = 0;
    end else if (sz != 0) begin
      age = (age < MW) ? age + 1 : MW;
    end
    if (acc && !byp) ll_q.push_back(in_e);
    if (has && (e.rd != '0)) begin
      exp_we    = 1'b1;
      exp_waddr = e.rd;
      exp_wdata = e.d;
    end else begin
      exp_we = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_wdata_i = 32'h33;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (lu_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", lu_ready_o); end
    total++; if (lu_pending_o !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", lu_pending_o); end
    total++; if (wb_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", wb_stall_o); end
    total++; if (gpr_we_o !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", gpr_we_o); end
    total++; if (gpr_waddr_o !== 5'd0) begin bad++; $display("FAIL reset_waddr: got %0d want 0", gpr_waddr_o); end
    total++; if (gpr_wdata_o !== 32'd0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", gpr_wdata_o); end
    wb_valid_i = 1'b0;
    #2 rstn_i = 1'b1;
    model_reset();
  endtask

  task automatic test_wb_only();
    wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_wdata_i = 32'hA5;
    tick();
    wb_valid_i = 1'b0;
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL wb_only_stall: got %b want 0", obs_stall); end
    total++; if (gpr_we_o !== 1'b1) begin bad++; $display("FAIL wb_only_we: got %b want 1", gpr_we_o); end
    total++; if (gpr_waddr_o !== 5'd5) begin bad++; $display("FAIL wb_only_waddr: got %0d want 5", gpr_waddr_o); end
    total++; if (gpr_wdata_o !== 32'hA5) begin bad++; $display("FAIL wb_only_wdata: got %0h want a5", gpr_wdata_o); end
    tick();
    total++; if (gpr_we_o !== 1'b0) begin bad++; $display("FAIL wb_only_idle_we: got %b want 0", gpr_we_o); end
    total++; if (gpr_waddr_o !== 5'd5) begin bad++; $display("FAIL wb_only_hold_addr: got %0d want 5", gpr_waddr_o); end
  endtask

  task automatic test_ll_preempt();
    int stalls = 0;
    int ll_written = 0;
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_wdata_i = 32'h1111;
    lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_wdata_i = 32'h7777;
    tick();
    lu_valid_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL preempt_stall_c%0d: got %b want %b", i, obs_stall, exp_stall); end
      if (obs_stall) begin
        stalls++;
        total++; if (gpr_waddr_o !== 5'd7 || gpr_wdata_o !== 32'h7777) begin
          bad++; $display("FAIL preempt_ll_write: got %0d/%0h want 7/7777", gpr_waddr_o, gpr_wdata_o);
        end
        ll_written++;
      end else begin
        total++; if (gpr_we_o !== 1'b1 || gpr_waddr_o !== 5'd3) begin
          bad++; $display("FAIL preempt_wb_write_c%0d: got we=%b addr=%0d want 1/3", i, gpr_we_o, gpr_waddr_o);
        end
      end
    end
    wb_valid_i = 1'b0;
    total++; if (stalls != 1) begin bad++; $display("FAIL preempt_stall_count: got %0d want 1", stalls); end
    total++; if (ll_written != 1) begin bad++; $display("FAIL preempt_ll_count: got %0d want 1", ll_written); end
  endtask

  task automatic test_fifo_full();
    logic [AW-1:0] log_q[$];
    wb_valid_i = 1'b1; wb_rd_i = 5'd4; wb_wdata_i = 32'h44;
    lu_valid_i = 1'b1; lu_rd_i = 5'd10; lu_wdata_i = 32'hA0;
    tick();
    lu_rd_i = 5'd11; lu_wdata_i = 32'hB0;
    tick();
    lu_rd_i = 5'd12; lu_wdata_i = 32'hC0;
    tick();
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", obs_ready); end
    total++; if (obs_pending !== 1'b1) begin bad++; $display("FAIL full_pending: got %b want 1", obs_pending); end
    wb_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL full_ready_c%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_ready && lu_valid_i) lu_valid_i = 1'b0;
      if (gpr_we_o) log_q.push_back(gpr_waddr_o);
    end
    total++; if (lu_valid_i !== 1'b0) begin bad++; $display("FAIL full_third_accept: got held=%b want 0", lu_valid_i); end
    total++; if (log_q.size() != 3) begin bad++; $display("FAIL full_write_count: got %0d want 3", log_q.size()); end
    else begin
      total++; if (log_q[0] !== 5'd10 || log_q[1] !== 5'd11 || log_q[2] !== 5'd12) begin
        bad++; $display("FAIL full_order: got %0d,%0d,%0d want 10,11,12", log_q[0], log_q[1], log_q[2]);
      end
    end
  endtask

  task automatic test_rd_zero();
    wb_valid_i = 1'b1; wb_rd_i = 5'd6; wb_wdata_i = 32'h66;
    tick();
    wb_rd_i = 5'd0; wb_wdata_i = 32'hFFFF;
    tick();
    wb_valid_i = 1'b0;
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL rd0_stall: got %b want 0", obs_stall); end
    total++; if (gpr_we_o !== 1'b0) begin bad++; $display("FAIL rd0_we: got %b want 0", gpr_we_o); end
    total++; if (gpr_waddr_o !== 5'd6 || gpr_wdata_o !== 32'h66) begin
      bad++; $display("FAIL rd0_hold: got %0d/%0h want 6/66", gpr_waddr_o, gpr_wdata_o);
    end
  endtask

  task automatic test_async_reset();
    int writes = 0;
    wb_valid_i = 1'b1; wb_rd_i = 5'd2; wb_wdata_i = 32'h22;
    lu_valid_i = 1'b1; lu_rd_i = 5'd20; lu_wdata_i = 32'h20;
    tick();
    lu_rd_i = 5'd21; lu_wdata_i = 32'h21;
    tick();
    lu_valid_i = 1'b0;
    total++; if (lu_pending_o !== 1'b1 || lu_ready_o !== 1'b0) begin
      bad++; $display("FAIL arst_pre: got pending=%b ready=%b want 1/0", lu_pending_o, lu_ready_o);
    end
    #3 rstn_i = 1'b0;
    #1;
    total++; if (lu_pending_o !== 1'b0) begin bad++; $display("FAIL arst_pending: got %b want 0", lu_pending_o); end
    total++; if (gpr_we_o !== 1'b0) begin bad++; $display("FAIL arst_we: got %b want 0", gpr_we_o); end
    total++; if (lu_ready_o !== 1'b1 || wb_stall_o !== 1'b0) begin
      bad++; $display("FAIL arst_hs: got ready=%b stall=%b want 1/0", lu_ready_o, wb_stall_o);
    end
    #2 rstn_i = 1'b1;
    model_reset();
    wb_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gpr_we_o) writes++;
    end
    total++; if (writes != 0) begin bad++; $display("FAIL arst_no_write: got %0d writes want 0", writes); end
  endtask

  task automatic test_latency();
    logic e1, e2;
`ifdef GPR_ARB_BYPASS_EN
    e1 = 1'b1; e2 = 1'b0;
`else
    e1 = 1'b0; e2 = 1'b1;
`endif
    lu_valid_i = 1'b1; lu_rd_i = 5'd9; lu_wdata_i = 32'h99;
    tick();
    lu_valid_i = 1'b0;
    total++; if (gpr_we_o !== e1) begin bad++; $display("FAIL lat_edge1_we: got %b want %b", gpr_we_o, e1); end
    tick();
    total++; if (gpr_we_o !== e2) begin bad++; $display("FAIL lat_edge2_we: got %b want %b", gpr_we_o, e2); end
    total++; if (gpr_waddr_o !== 5'd9 || gpr_wdata_o !== 32'h99) begin
      bad++; $display("FAIL lat_payload: got %0d/%0h want 9/99", gpr_waddr_o, gpr_wdata_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wb_valid_i = ($urandom_range(0, 99) < 55);
      wb_rd_i    = AW'($urandom_range(0, 31));
      wb_wdata_i = $urandom;
      lu_valid_i = ($urandom_range(0, 99) < 40);
      lu_rd_i    = AW'($urandom_range(0, 31));
      lu_wdata_i = $urandom;
      tick();
      total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall_c%0d: got %b want %b", i, obs_stall, exp_stall); end
      total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready_c%0d: got %b want %b", i, obs_ready, exp_ready); end
      total++; if (obs_pending !== exp_pending) begin bad++; $display("FAIL rnd_pending_c%0d: got %b want %b", i, obs_pending, exp_pending); end
      total++; if (gpr_we_o !== exp_we) begin bad++; $display("FAIL rnd_we_c%0d: got %b want %b", i, gpr_we_o, exp_we); end
      total++; if (gpr_waddr_o !== exp_waddr) begin bad++; $display("FAIL rnd_waddr_c%0d: got %0d want %0d", i, gpr_waddr_o, exp_waddr); end
      total++; if (gpr_wdata_o !== exp_wdata) begin bad++; $display("FAIL rnd_wdata_c%0d: got %0h want %0h", i, gpr_wdata_o, exp_wdata); end
    end
    wb_valid_i = 1'b0;
    lu_valid_i = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wb_only();
    test_ll_preempt();
    test_fifo_full();
    test_rd_zero();
    test_async_reset();
    test_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
